// File: rtl/ddc_pkg.sv
// Shared types and elaboration-time helpers for the real-to-baseband downconverter:
// quadrant decode, quarter-wave sine table generation and output scaling.
package ddc_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    localparam real PI = 3.14159265358979323846;

    // Entry k of the quarter-wave table, sampled at bin centres so lut[k] and lut[~k]
    // are exact mirrors and no quadrant ever needs a special zero/peak entry.
    function automatic int lut_entry(input int k, input int lut_aw, input int coef_w);
        real peak;
        real arg;
        peak = real'((1 << (coef_w - 1)) - 1);
        arg  = PI / 2.0 * (real'(k) + 0.5) / real'(1 << lut_aw);
        return $rtoi(peak * $sin(arg) + 0.5);
    endfunction

    function automatic int scale_shift(input int coef_w, input int decim_log2, input int gain_log2);
        return coef_w - 1 + decim_log2 - gain_log2;
    endfunction

    function automatic int count_width(input int decim_log2);
        return (decim_log2 > 0) ? decim_log2 : 1;
    endfunction

endpackage

// File: rtl/ddc_nco_mixer_if.sv
// Sample-stream, tuning and status signals of the downconverter; the DUT sits on
// the slave modport, the front end / bench drives the master modport.
interface ddc_nco_mixer_if #(
    parameter int PHASE_W = 32,
    parameter int DATA_W  = 16,
    parameter int OUT_W   = 16
);
    logic [PHASE_W-1:0]       ftw_in;
    logic                     ftw_load;
    logic                     phase_clr;
    logic                     in_valid;
    logic signed [DATA_W-1:0] real_in;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  i_out;
    logic signed [OUT_W-1:0]  q_out;
    logic                     ovf;
    logic                     ovf_clr;

    modport master (
        output ftw_in, ftw_load, phase_clr, in_valid, real_in, ovf_clr,
        input  out_valid, i_out, q_out, ovf
    );

    modport slave (
        input  ftw_in, ftw_load, phase_clr, in_valid, real_in, ovf_clr,
        output out_valid, i_out, q_out, ovf
    );
endinterface

// File: rtl/nco_quarter_lut.sv
// Phase -> {sin, cos}: registered quarter-wave ROM read of lut[a] and lut[~a],
// then quadrant folding on the registered values (pipeline stage S1).
module nco_quarter_lut
    import ddc_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int LUT_AW = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [LUT_AW+1:0]        phase_i,
    output logic signed [COEF_W-1:0] sin_o,
    output logic signed [COEF_W-1:0] cos_o
);
    localparam int DEPTH = 1 << LUT_AW;

    logic [COEF_W-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [COEF_W-1:0] ENTRY = COEF_W'(lut_entry(k, LUT_AW, COEF_W));
        assign rom[k] = ENTRY;
    end

    logic [LUT_AW-1:0]        addr;
    logic signed [COEF_W-1:0] mag_a_q;
    logic signed [COEF_W-1:0] mag_na_q;
    quad_e                    quad_q;

    assign addr = phase_i[LUT_AW-1:0];

    // NOTE: registers are updated with <= so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_a_q  <= '0;
            mag_na_q <= '0;
            quad_q   <= QUAD_0;
        end else begin
            mag_a_q  <= rom[addr];
            mag_na_q <= rom[~addr];
            quad_q   <= quad_e'(phase_i[LUT_AW+1:LUT_AW]);
        end
    end

    // NOTE: both outputs get a default first so no path through the case infers a latch.
    always_comb begin
        sin_o = '0;
        cos_o = '0;
        unique case (quad_q)
            QUAD_0: begin sin_o =  mag_a_q;  cos_o =  mag_na_q; end
            QUAD_1: begin sin_o =  mag_na_q; cos_o = -mag_a_q;  end
            QUAD_2: begin sin_o = -mag_a_q;  cos_o = -mag_na_q; end
            QUAD_3: begin sin_o = -mag_na_q; cos_o =  mag_a_q;  end
        endcase
    end

endmodule

// File: rtl/ddc_nco_mixer.sv
// Real-to-baseband downconverter: NCO phase accumulator, I/Q mixer, integrate-and-dump
// decimator and round/saturate, as a four-stage pipeline (S0 phase, S1 ROM, S2 mult, S3 acc).
module ddc_nco_mixer
    import ddc_pkg::*;
#(
    parameter int               PHASE_W    = 32,
    parameter int               DATA_W     = 16,
    parameter int               COEF_W     = 16,
    parameter int               LUT_AW     = 10,
    parameter int               OUT_W      = 16,
    parameter int               DECIM_LOG2 = 0,
    parameter int               GAIN_LOG2  = 0,
    parameter bit               NEG_Q      = 1'b1,
    parameter logic [PHASE_W-1:0] FTW_RST  = '0
) (
    input logic            clk,
    input logic            reset_n,
    ddc_nco_mixer_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + DECIM_LOG2;
    localparam int ACC_X  = ACC_W + 1;
    localparam int SHIFT  = scale_shift(COEF_W, DECIM_LOG2, GAIN_LOG2);
    localparam int CNT_W  = count_width(DECIM_LOG2);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic signed [ACC_W:0] RND_HALF = ACC_X'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX  = ACC_X'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN  = -OUT_MAX - ACC_X'(1);

    logic [PHASE_W-1:0]       phase_acc_q, ftw_q;
    logic [LUT_AW+1:0]        s0_phase_q;
    logic signed [DATA_W-1:0] s0_sample_q, s1_sample_q;
    logic                     s0_valid_q, s1_valid_q, s2_valid_q;
    logic signed [COEF_W-1:0] sin_w, cos_w;
    logic signed [PROD_W-1:0] s2_i_prod_d, s2_q_prod_d, s2_i_prod_q, s2_q_prod_q, q_raw;
    logic signed [ACC_W-1:0]  acc_i_q, acc_q_q, acc_i_sum, acc_q_sum;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [OUT_W-1:0]  i_rs, q_rs, i_out_q, q_out_q;
    logic                     i_clip, q_clip, group_done, out_valid_q, ovf_q;

    // S0: the sample takes the current phase; the step uses the pre-load tuning word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_acc_q <= '0;
            ftw_q       <= FTW_RST;
            s0_valid_q  <= 1'b0;
            s0_sample_q <= '0;
            s0_phase_q  <= '0;
        end else begin
            if (bus.ftw_load) ftw_q <= bus.ftw_in;
            if (bus.phase_clr) begin
                phase_acc_q <= '0;
                s0_valid_q  <= 1'b0;
            end else begin
                s0_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s0_sample_q <= bus.real_in;
                    s0_phase_q  <= phase_acc_q[PHASE_W-1 -: LUT_AW+2];
                    phase_acc_q <= phase_acc_q + ftw_q;
                end
            end
        end
    end

    nco_quarter_lut #(
        .COEF_W (COEF_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .phase_i (s0_phase_q),
        .sin_o   (sin_w),
        .cos_o   (cos_w)
    );

    always_comb begin
        s2_i_prod_d = PROD_W'(s1_sample_q) * PROD_W'(cos_w);
        q_raw       = PROD_W'(s1_sample_q) * PROD_W'(sin_w);
        s2_q_prod_d = NEG_Q ? -q_raw : q_raw;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s1_sample_q <= '0;
            s2_i_prod_q <= '0;
            s2_q_prod_q <= '0;
        end else begin
            s1_valid_q  <= s0_valid_q & ~bus.phase_clr;
            s2_valid_q  <= s1_valid_q & ~bus.phase_clr;
            s1_sample_q <= s0_sample_q;
            s2_i_prod_q <= s2_i_prod_d;
            s2_q_prod_q <= s2_q_prod_d;
        end
    end

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc,
                                                          output logic clip);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] shifted;
        rnd     = ACC_X'(acc) + RND_HALF;
        shifted = rnd >>> SHIFT;
        clip    = (shifted > OUT_MAX) || (shifted < OUT_MIN);
        if (shifted > OUT_MAX)      return OUT_W'(OUT_MAX);
        else if (shifted < OUT_MIN) return OUT_W'(OUT_MIN);
        else                        return OUT_W'(shifted);
    endfunction

    // The first product of a group reloads the accumulator, so no sample is lost at a dump.
    always_comb begin
        acc_i_sum = ACC_W'(s2_i_prod_q);
        acc_q_sum = ACC_W'(s2_q_prod_q);
        if (cnt_q != '0) begin
            acc_i_sum = acc_i_sum + acc_i_q;
            acc_q_sum = acc_q_sum + acc_q_q;
        end
        i_rs       = round_sat(acc_i_sum, i_clip);
        q_rs       = round_sat(acc_q_sum, q_clip);
        group_done = s2_valid_q & ~bus.phase_clr & (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            out_valid_q <= 1'b0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= group_done;
            if (bus.phase_clr) begin
                cnt_q   <= '0;
                acc_i_q <= '0;
                acc_q_q <= '0;
            end else if (s2_valid_q) begin
                cnt_q   <= group_done ? '0 : cnt_q + CNT_W'(1);
                acc_i_q <= acc_i_sum;
                acc_q_q <= acc_q_sum;
            end
            if (group_done) begin
                i_out_q <= i_rs;
                q_out_q <= q_rs;
            end
            // A fresh clip outranks a simultaneous clear.
            if (group_done && (i_clip || q_clip)) ovf_q <= 1'b1;
            else if (bus.ovf_clr)                 ovf_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.i_out     = i_out_q;
    assign bus.q_out     = q_out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/ddc_nco_mixer.md
# ddc_nco_mixer

Parametrised real-to-baseband downconverter. A synthesizable NCO uses a phase accumulator, a quarter-wave sine ROM and a runtime-loadable tuning word. It mixes a real sample stream to I/Q, then applies optional integrate-and-dump decimation by 2^DECIM_LOG2, with rounding, gain and saturation. It sits between the ADC/real-sample front end and the MSK demodulator's matched filter/timing recovery.

## Interface
- PHASE_W, 32, phase accumulator / tuning word width
- DATA_W, 16, signed input sample width
- COEF_W, 16, signed NCO amplitude width; peak = 2^(COEF_W-1)-1
- LUT_AW, 10, quarter-wave ROM address bits (2^LUT_AW entries)
- OUT_W, 16, signed I/Q output width
- DECIM_LOG2, 0, decimation exponent, 0..8
- GAIN_LOG2, 0, post-accumulation left shift, 0..4
- NEG_Q, 1, 1: Q = −x·sin (conjugate mix); 0: Q = +x·sin
- FTW_RST, 0, tuning word value after reset
- clk  in  1  clock (one clock domain)
- reset_n  in  1  asynchronous active-low reset
- ftw_in  in  PHASE_W  new tuning word
- ftw_load  in  1  load ftw_in into ftw_reg
- phase_clr  in  1  synchronous clear of phase/decimation state
- in_valid  in  1  real_in valid this cycle
- real_in  in  DATA_W  signed real sample
- out_valid  out  1  I/Q valid, one-cycle pulse per output
- i_out  out  OUT_W  signed baseband I
- q_out  out  OUT_W  signed baseband Q
- ovf  out  1  sticky saturation flag
- ovf_clr  in  1  clears ovf

## Operation
- Reset values: phase_acc=0, ftw_reg=FTW_RST, decim count=0, accumulators=0, pipeline valids=0, out_valid=0, i_out=0, q_out=0, ovf=0.
- NCO advances only on in_valid. The sample uses the current phase_acc; then phase_acc <= phase_acc + ftw_reg, modulo 2^PHASE_W.
- ftw_load: ftw_reg <= ftw_in. If it coincides with in_valid, the increment uses the old ftw_reg.
- Phase decode: quadrant = phase[PHASE_W-1 -: 2]; addr a = the next LUT_AW bits.
- ROM entry k = round(peak·sin(π/2·(k+0.5)/2^LUT_AW)).
- sin by quadrant: q0 lut[a], q1 lut[~a], q2 −lut[a], q3 −lut[~a]. cos = sin evaluated at quadrant+1.
- Products: x·cos and ±x·sin, full DATA_W+COEF_W bits.
- Accumulate 2^DECIM_LOG2 products per channel with DECIM_LOG2 guard bits. The output group closes on the last valid sample, and the accumulator reloads with the next sample (no lost samples).
- Scaling: s = COEF_W−1+DECIM_LOG2−GAIN_LOG2 (requires s ≥ 1). Output = (acc + 2^(s−1)) >>> s, i.e. round half up.
- Saturate to OUT_W. Any clipped I or Q sets ovf.
- ovf_clr clears ovf. If ovf_clr and a new clip coincide, ovf = 1 (set wins).
- phase_clr: phase_acc=0, decim count=0, accumulators=0, and all in-flight pipeline valids cleared. An in_valid sample in the same cycle is dropped. ftw_reg is kept. ftw_load in the same cycle is still honoured.
- Gaps in in_valid are allowed anywhere; the pipeline holds state only through valid bits.

## Timing
- Four-stage pipeline: S0 register sample+phase; S1 ROM read/quadrant sign; S2 multiply; S3 accumulate/round/saturate → outputs.
- out_valid asserts 4 cycles after the in_valid that completes a group (DECIM_LOG2=0: every sample).
- i_out/q_out hold their value between out_valid pulses.
- Throughput: one sample per clock, no backpressure.
- Reset mid-operation: all state is cleared immediately and asynchronously. The first output after release comes from a fresh group, 4 cycles after its last sample.

## Structure
- Package ddc_pkg: quadrant decode enum, ROM-init function (compile-time real math, synthesizable constant), clog2/scaling helpers.
- Sub-module nco_quarter_lut: phase → {sin, cos}, 1-cycle registered ROM plus quadrant folding (S1).
- Top: accumulator, mixer, decimator, round/saturate.

## Test plan
- Reset with in_valid toggling → out_valid=0, i_out=q_out=0, ovf=0 throughout. After release, first out_valid exactly 4 cycles after the first in_valid.
- Defaults, ftw=0, real_in=16384 constant → i_out=16384, q_out=−12 (lut[0]=25, lut[1023]=32767).
- ftw_load 0x4000_0000, real_in=16384 → i_out repeats 16384, −12, −16384, 12 (±1 LSB); q_out is in quadrature. ftw_load coinciding with in_valid → that sample uses the old step.
- DECIM_LOG2=2, ftw=0, four valid samples 1000/2000/3000/4000 with random gaps → single out_valid, i_out=2500, 4 cycles after the 4th sample.
- GAIN_LOG2=1, ftw=0, real_in=32767 → i_out=32767 saturated, ovf=1 and sticky until ovf_clr. Simultaneous ovf_clr + clip → ovf stays 1.
- phase_clr mid-group (DECIM_LOG2=2, after 2 samples) plus in-flight samples → no out_valid from those samples. Next group is a clean 4-sample group starting at phase 0; ftw_reg unchanged.
